// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS_32 hardware trace observer: capture states,
// sample width and the trigger compare used while armed.
package mips_dbg_pkg;

  // Width of one observed core bus and of one packed trace sample
  localparam int OBS_W    = 32;
  localparam int SAMPLE_W = 3 * OBS_W;

  // Capture controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // Masked equality; a zero mask matches any operand value
  function automatic logic trig_hit(input logic [OBS_W-1:0] a,
                                    input logic [OBS_W-1:0] mask,
                                    input logic [OBS_W-1:0] value);
    return (a & mask) == (value & mask);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port and one registered read port.
// Contents are deliberately not reset so the array can map onto block RAM.
module trace_ram
  import mips_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one sample per write-enabled cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; the output holds its value while re is low
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mips_trace_capture.sv
// Hardware trace observer for the MIPS_32 core. Samples {readDataMem, ALUa,
// ALUb} into a circular buffer while armed, freezes a pre/post window around
// an ALUa trigger, then streams the window oldest-first over valid/ready.
module mips_trace_capture
  import mips_dbg_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 4,
  parameter int DW       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic [DW-1:0]              trig_mask,
  input  logic [DW-1:0]              trig_value,
  input  logic [DW-1:0]              readDataMem,
  input  logic [DW-1:0]              ALUa,
  input  logic [DW-1:0]              ALUb,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [3*DW-1:0]            rd_data,
  output logic                       rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Samples still to be written after the trigger sample itself
  localparam logic [CW-1:0] POST_N   = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_TOT = CW'(DEPTH - PRE_TRIG);
  localparam logic [CW-1:0] PRE_MAX  = CW'(PRE_TRIG);

  state_e          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   trig_ptr;
  logic [AW-1:0]   trig_now;
  logic [CW-1:0]   pre_cnt;
  logic [CW-1:0]   post_cnt;
  logic [CW-1:0]   rd_idx;
  logic [3*DW-1:0] sample;
  logic [3*DW-1:0] ram_q;
  logic            hit;
  logic            sample_we;
  logic            go_drain;
  logic            fetch;

  // Decode write enable, trigger, the drain hand-over and RAM fetch requests
  always_comb begin
    sample    = {readDataMem, ALUa, ALUb};
    hit       = trig_hit(ALUa, trig_mask, trig_value);
    sample_we = (state == ARMED) || (state == CAPTURE);
    trig_now  = (state == ARMED) ? wr_ptr : trig_ptr;
    go_drain  = ((state == ARMED) && hit && (POST_N == '0)) ||
                ((state == CAPTURE) && (post_cnt == CW'(1)));
    fetch     = (state == DRAIN) &&
                ((!rd_valid && (rd_idx == '0)) ||
                 (rd_valid && rd_ready && !rd_last));
  end

  assign busy    = (state != IDLE);
  assign rd_data = rd_valid ? ram_q : '0;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (3 * DW)
  ) u_ram (
    .clk   (clk),
    .we    (sample_we),
    .waddr (wr_ptr),
    .wdata (sample),
    .re    (fetch),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Capture FSM, window pointers and read-port handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      trig_ptr <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      rd_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= ARMED;
            done    <= 1'b0;
            pre_cnt <= '0;
            wr_ptr  <= '0;
          end
        end
        ARMED: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (hit) begin
            trig_ptr <= wr_ptr;
            post_cnt <= POST_N;
            state    <= CAPTURE;
          end else if (pre_cnt < PRE_MAX) begin
            pre_cnt <= pre_cnt + CW'(1);
          end
        end
        CAPTURE: begin
          wr_ptr   <= wr_ptr + AW'(1);
          post_cnt <= post_cnt - CW'(1);
        end
        DRAIN: begin
          if (fetch) begin
            rd_ptr   <= rd_ptr + AW'(1);
            rd_idx   <= rd_idx + CW'(1);
            rd_valid <= 1'b1;
            rd_last  <= ((rd_idx + CW'(1)) == count);
          end else if (rd_valid && rd_ready && rd_last) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (go_drain) begin
        state    <= DRAIN;
        count    <= pre_cnt + POST_TOT;
        rd_ptr   <= trig_now - pre_cnt[AW-1:0];
        rd_idx   <= '0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_trace_capture.sv
// Scoreboard bench for mips_trace_capture (DEPTH=16, PRE_TRIG=4): each capture
// queues its expected window, a negedge monitor compares every transfer.
module tb_mips_trace_capture;

  typedef struct packed {
    logic [95:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [31:0] trig_mask;
  logic [31:0] trig_value;
  logic [31:0] readDataMem;
  logic [31:0] ALUa;
  logic [31:0] ALUb;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic        rd_valid;
  logic        rd_ready;
  logic [95:0] rd_data;
  logic        rd_last;

  int          errors;
  int          checks;
  exp_t        exp_q[$];
  logic        stalled;
  logic [95:0] heldData;
  logic        heldLast;

  mips_trace_capture #(
    .DEPTH    (16),
    .PRE_TRIG (4),
    .DW       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .readDataMem (readDataMem),
    .ALUa        (ALUa),
    .ALUb        (ALUb),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the flow wedges somewhere unforeseen
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sample presented on cycle k: {readDataMem, ALUa, ALUb}
  function automatic logic [95:0] mk(input int k);
    return {32'hD000_0000 | 32'(k), 32'(k), 32'hB000_0000 | 32'(k)};
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: compare each transfer against the queue and hold stability on stalls
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (stalled) begin
        checkOutput("stall_data", rd_data, heldData);
        checkOutput("stall_last", 96'(rd_last), 96'(heldLast));
      end
      if (rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_entry got=%h expected=none", rd_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("entry_data", rd_data, e.data);
          checkOutput("entry_last", 96'(rd_last), 96'(e.last));
        end
        stalled = 1'b0;
      end else begin
        stalled  = 1'b1;
        heldData = rd_data;
        heldLast = rd_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Arm, drive ALUa = 0,1,2.. from the first ARMED cycle and drain the window.
  // readyMode 1 applies the ready pattern 1,0,0,1,0; abortAfter>0 resets
  // after that many transfers.
  task automatic applyStimulus(input logic [31:0] tv, input logic [31:0] tm,
                               input int firstK, input int nEnt,
                               input int expCount, input int readyMode,
                               input bit rearm, input int abortAfter);
    int          k;
    int          xfers;
    bit          finished;
    bit          aborted;
    logic [95:0] v;
    logic [4:0]  pat;
    exp_t        e;
    pat = 5'b01001;
    for (int i = 0; i < nEnt; i++) begin
      e.data = mk(firstK + i);
      e.last = (i == nEnt - 1);
      exp_q.push_back(e);
    end
    trig_value = tv;
    trig_mask  = tm;
    rd_ready   = 1'b0;
    arm        = 1'b1;
    k          = 0;
    xfers      = 0;
    finished   = 1'b0;
    aborted    = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (abortAfter > 0 && xfers == abortAfter) begin
        rst      = 1'b1;
        rd_ready = 1'b0;
        arm      = 1'b0;
        aborted  = 1'b1;
        break;
      end
      arm         = rearm && (k == 3);
      v           = mk(k);
      readDataMem = v[95:64];
      ALUa        = v[63:32];
      ALUb        = v[31:0];
      k++;
      rd_ready = (readyMode == 0) ? 1'b1 : pat[cyc % 5];
      if (rd_valid && rd_ready) xfers++;
    end
    arm = 1'b0;
    if (abortAfter > 0) begin
      checkOutput("abort_reached", 96'(aborted), 96'(1));
      checkOutput("abort_remaining", 96'(exp_q.size()), 96'(nEnt - abortAfter));
      @(posedge clk);
      #1;
      checkOutput("abort_rd_valid", 96'(rd_valid), 96'(0));
      checkOutput("abort_busy", 96'(busy), 96'(0));
      checkOutput("abort_done", 96'(done), 96'(0));
      checkOutput("abort_count", 96'(count), 96'(0));
      exp_q.delete();
      rst = 1'b0;
    end else begin
      checkOutput("drain_finished", 96'(finished), 96'(1));
      checkOutput("count", 96'(count), 96'(expCount));
      checkOutput("done", 96'(done), 96'(1));
      checkOutput("busy_after", 96'(busy), 96'(0));
      checkOutput("rd_valid_after", 96'(rd_valid), 96'(0));
      checkOutput("queue_empty", 96'(exp_q.size()), 96'(0));
      exp_q.delete();
    end
  endtask

  // Test sequence
  initial begin
    errors      = 0;
    checks      = 0;
    stalled     = 1'b0;
    heldData    = '0;
    heldLast    = 1'b0;
    rst         = 1'b1;
    arm         = 1'b1;
    trig_mask   = '0;
    trig_value  = '0;
    readDataMem = '0;
    ALUa        = '0;
    ALUb        = '0;
    rd_ready    = 1'b0;

    $display("[TB] reset held with arm=1");
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rst_busy", 96'(busy), 96'(0));
      checkOutput("rst_done", 96'(done), 96'(0));
      checkOutput("rst_count", 96'(count), 96'(0));
      checkOutput("rst_rd_valid", 96'(rd_valid), 96'(0));
      checkOutput("rst_rd_data", rd_data, 96'(0));
      checkOutput("rst_rd_last", 96'(rd_last), 96'(0));
    end
    rst = 1'b0;
    arm = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_busy", 96'(busy), 96'(0));
    checkOutput("idle_done", 96'(done), 96'(0));

    $display("[TB] nominal trigger at ALUa=10");
    applyStimulus(32'd10, 32'hFFFF_FFFF, 6, 16, 16, 0, 1'b0, 0);

    $display("[TB] trigger on first armed cycle");
    applyStimulus(32'd0, 32'hFFFF_FFFF, 0, 12, 12, 0, 1'b0, 0);

    $display("[TB] backpressure on read port");
    applyStimulus(32'd10, 32'hFFFF_FFFF, 6, 16, 16, 1, 1'b0, 0);

    $display("[TB] zero mask with arm pulsed during capture");
    applyStimulus(32'd5, 32'h0000_0000, 0, 12, 12, 0, 1'b1, 0);

    $display("[TB] reset after five transfers");
    applyStimulus(32'd10, 32'hFFFF_FFFF, 6, 16, 0, 0, 1'b0, 5);

    $display("[TB] full capture after reset");
    applyStimulus(32'd10, 32'hFFFF_FFFF, 6, 16, 16, 1, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_trace_capture.md
Name: mips_trace_capture

Overview:
- Hardware observer for the MIPS_32 core. It samples the core's `readDataMem`, `ALUa` and `ALUb` every clock into a circular trace buffer.
- An armed trigger on `ALUa` freezes a pre/post-trigger window.
- The window is then streamed out oldest-first over a valid/ready read port.
- It sits beside `top` as the hardware counterpart of the simulation monitor, usable on silicon/FPGA.

Parameters:
- DEPTH, 16, trace entries; power of two, ≥4.
- PRE_TRIG, 4, maximum samples retained before the trigger sample; must be < DEPTH.
- DW, 32, width of each observed bus.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  start request, sampled only in IDLE
- trig_mask  in  DW  bit mask for trigger compare
- trig_value  in  DW  trigger compare value
- readDataMem  in  DW  observed memory read data
- ALUa  in  DW  observed ALU operand A
- ALUb  in  DW  observed ALU operand B
- busy  out  1  high in ARMED, CAPTURE, DRAIN
- done  out  1  high from end of DRAIN until next arm or rst
- count  out  $clog2(DEPTH)+1  entries in the frozen window
- rd_valid  out  1  rd_data holds a valid entry
- rd_ready  in  1  consumer accepts an entry
- rd_data  out  3*DW  {readDataMem, ALUa, ALUb}
- rd_last  out  1  qualifies the final entry of the window

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; busy, done, count, rd_valid, rd_data, rd_last all 0.
  - wr_ptr, rd_ptr, pre_cnt, post_cnt all 0.
  - RAM contents are not cleared.
  - Reset wins over every other event in the same cycle, including mid-CAPTURE and mid-DRAIN.
- Sample = {readDataMem, ALUa, ALUb} at the current edge.
- Trigger condition: `(ALUa & trig_mask) == (trig_value & trig_mask)`. trig_mask = 0 fires on the first compared cycle.
- IDLE:
  - When arm=1, go to ARMED; clear done, pre_cnt, wr_ptr.
  - When arm=0, remain in IDLE.
- ARMED (every cycle):
  - Write the sample at wr_ptr; wr_ptr++ mod DEPTH.
  - If the trigger hits this cycle: trig_ptr = this write address; post_cnt = DEPTH-PRE_TRIG-1; go to CAPTURE, or straight to DRAIN if post_cnt = 0.
  - Otherwise: pre_cnt = min(pre_cnt+1, PRE_TRIG).
  - The trigger sample counts as the first post sample.
- CAPTURE:
  - Each cycle write the sample and advance wr_ptr; post_cnt--.
  - The cycle post_cnt reaches 0 (last sample written), go to DRAIN.
  - Retained pre samples are never overwritten, since pre_cnt ≤ PRE_TRIG.
- Entering DRAIN:
  - count = pre_cnt + DEPTH - PRE_TRIG.
  - rd_ptr = (trig_ptr - pre_cnt) mod DEPTH.
- DRAIN:
  - RAM read is synchronous. rd_valid rises the cycle after DRAIN entry, with rd_data = the oldest entry.
  - Handshake: a transfer occurs when rd_valid && rd_ready. While rd_valid && !rd_ready, rd_data and rd_last hold stable.
  - On a transfer with more entries remaining, the next entry is presented the following cycle with no bubble; a prefetch register is allowed.
  - rd_last = 1 on entry number count.
  - On the transfer with rd_last: go to IDLE; rd_valid=0, done=1, busy=0 next cycle. count holds its value.
- arm outside IDLE is ignored. Sampling stops outside ARMED and CAPTURE.
- Simultaneous trigger on the first ARMED cycle: pre_cnt=0 and count=DEPTH-PRE_TRIG.
- Pointer arithmetic wraps modulo DEPTH; no overflow state exists.

Decomposition:
- Package `mips_dbg_pkg` holds:
  - state enum {IDLE, ARMED, CAPTURE, DRAIN};
  - localparam SAMPLE_W = 3*DW;
  - helper function `trig_hit(a, mask, value)`.
- Sub-module `trace_ram`: DEPTH×SAMPLE_W simple dual-port RAM with one write port and one synchronous read port. It has no reset.
- FSM, pointers and handshake live in mips_trace_capture.

Test Plan (DEPTH=16, PRE_TRIG=4):
- Reset: hold rst=1 for 3 cycles with arm=1 -> all outputs 0 and state stays IDLE; after release with arm=0, busy=0.
- Nominal: arm, ALUa = 0,1,2,… per cycle, mask=FFFFFFFF, value=10, rd_ready=1 -> 16 entries with ALUa 6…21, rd_last only on 21, count=16, done=1 after, busy=0.
- Early trigger: value=0 (matches the first ARMED cycle) -> pre_cnt=0, count=12, entries ALUa 0…11.
- Backpressure: nominal case with rd_ready pattern 1,0,0,1,0,1… -> rd_data stable during stalls; exactly 16 unique, ordered entries; none dropped or duplicated.
- Mask zero plus ignored arm: mask=0, arm pulsed again in CAPTURE -> trigger on the first ARMED cycle; the second arm has no effect; count=12.
- Reset mid-DRAIN: assert rst after 5 transfers -> next cycle rd_valid=0, busy=0, done=0, count=0; re-arm runs a correct full capture.
